udm_bus_split: RTL and testbench
================================

UDM_BUS_SPLIT -- requirements
Module: udm_bus_split

Interface
REQ-001 SHALL have parameter N_SLV, default 4, number of slave channels (1..8).
REQ-002 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads (1..15).
REQ-003 SHALL have parameter SLV_BASE, N_SLV*32 bits, default 0x0000_0000 at slot 0, 0x1000_0000 at slot 1, and so on, giving the per-slave base address (slot i at bits [32i+31:32i]).
REQ-004 SHALL have parameter SLV_MASK, N_SLV*32 bits, default 0xF000_0000 in every slot, giving the per-slave compare mask.
REQ-005 SHALL have parameter ERR_RDATA, 32 bits, default 0xDEAD_BEEF, returned for unmapped reads.
REQ-006 SHALL have ports: clk_i  in  1  the single clock; rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have master inputs: m_req_i 1; m_we_i 1; m_addr_bi 32; m_be_bi 4; m_wdata_bi 32.
REQ-008 SHALL have master outputs: m_ack_o 1 (request accepted); m_resp_o 1 (read data valid); m_rdata_bo 32.
REQ-009 SHALL have slave outputs: s_req_o N_SLV; s_we_o 1; s_addr_bo 32; s_be_bo 4; s_wdata_bo 32 (we/addr/be/wdata broadcast to all slaves).
REQ-010 SHALL have slave inputs: s_ack_i N_SLV; s_resp_i N_SLV; s_rdata_bi N_SLV*32.
REQ-011 SHALL have status output decerr_o, 1 bit, a one-cycle pulse when an unmapped access is accepted.

Function
REQ-012 SHALL decode dec_id as the lowest i with (m_addr_bi & SLV_MASK[i]) == SLV_BASE[i]; if no slot matches, dec_id SHALL be N_SLV (the error slot).
REQ-013 SHALL hold registers cnt (outstanding reads, 0..MAX_OUTST) and cur_id (slot owning those reads).
REQ-014 SHALL assert stall when rst_i=1, or cnt!=0 and dec_id!=cur_id, or the request is a read and cnt==MAX_OUTST.
REQ-015 SHALL drive s_req_o[dec_id] = m_req_i & !stall and all other s_req_o bits low.
REQ-016 SHALL drive m_ack_o combinationally: s_ack_i[dec_id] & m_req_i & !stall for a mapped access; m_req_i & !stall for the error slot (zero-cycle ack).
REQ-017 On an accepted read (m_req_i & m_ack_o & !m_we_i), SHALL increment cnt and load cur_id <= dec_id.
REQ-018 On m_resp_o=1, SHALL decrement cnt; an accept and a response in the same cycle SHALL leave cnt unchanged and still load cur_id.
REQ-019 For cnt!=0 and cur_id<N_SLV, SHALL set m_resp_o = s_resp_i[cur_id] and m_rdata_bo = s_rdata_bi[cur_id].
REQ-020 Each accepted error-slot read SHALL produce m_resp_o=1 with m_rdata_bo=ERR_RDATA exactly one cycle later; back-to-back error reads SHALL give back-to-back responses.
REQ-021 Accepted error-slot writes SHALL be acknowledged and discarded; decerr_o SHALL pulse in the cycle after any error-slot accept.
REQ-022 SHALL ignore s_resp_i from a slot other than cur_id, or while cnt==0.
REQ-023 When m_resp_o=0, SHALL drive m_rdata_bo to 0.
REQ-024 Writes SHALL NOT change cnt; a write to a slot other than cur_id SHALL stall until cnt==0.

Reset
REQ-025 SHALL clear cnt, cur_id, the error-response flag and decerr_o on rst_i at the clock edge.
REQ-026 While rst_i=1, SHALL hold m_ack_o=0 and s_req_o=0 combinationally.
REQ-027 A reset with reads outstanding SHALL drop them; later s_resp_i for those reads SHALL be ignored per REQ-022.

Structure
REQ-028 SHALL place the ERR_RDATA default, the bus widths (32/4) and the slot-index width function in package udm_bus_pkg.
REQ-029 SHALL implement the address decode (REQ-012) as the combinational sub-module udm_bus_decoder.
REQ-030 SHALL size cnt as $clog2(MAX_OUTST+1) bits and cur_id as $clog2(N_SLV+1) bits.

Verification
REQ-031 Slot 1 read at 0x1000_0004, s_ack_i[1] on the same cycle, s_resp_i[1] 3 cycles later with 0x1234_5678 -> s_req_o=4'b0010, m_ack_o=1, cnt 1 then 0, m_rdata_bo=0x1234_5678.
REQ-032 Five reads to slot 0 with the slave never responding, MAX_OUTST=4 -> 4 acks, 5th stalled (m_ack_o=0) until one response arrives, then accepted the same cycle.
REQ-033 Read to slot 0 pending, then a read to slot 2 -> slot 2 stalled, s_req_o[2]=0 until slot-0 response; accepted that cycle, cnt stays 1, cur_id=2.
REQ-034 Read at 0x5000_0000 with defaults N_SLV=4 -> m_ack_o=1 same cycle; next cycle m_resp_o=1, m_rdata_bo=0xDEAD_BEEF, decerr_o=1.
REQ-035 Three reads outstanding, rst_i for 1 cycle, late s_resp_i[0] -> cnt=0, m_resp_o stays 0.
REQ-036 Spurious s_resp_i[3] with cnt==0 -> m_resp_o=0, no state change.

Source files
------------

// File: rtl/udm_bus_pkg.sv
// Shared widths, defaults and helpers for the udm bus splitter.
package udm_bus_pkg;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam logic [DW-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  // Bits needed to hold values 0..n (n is the error slot / full count).
  function automatic int slot_w(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Slot i at i*0x1000_0000 for up to eight slots; callers cast down to N_SLV*DW.
  function automatic logic [8*DW-1:0] def_base();
    logic [8*DW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = DW'(i) << 28;
    return r;
  endfunction
endpackage

// File: rtl/udm_bus_decoder.sv
// Address decoder: lowest matching slot wins, N_SLV when nothing matches.
module udm_bus_decoder
  import udm_bus_pkg::*;
#(
  parameter int N_SLV = 4,
  parameter int IW    = slot_w(N_SLV)
) (
  input  logic [DW-1:0]       addr,
  input  logic [N_SLV*DW-1:0] base,
  input  logic [N_SLV*DW-1:0] mask,
  output logic [IW-1:0]       dec_id
);
  always_comb begin
    dec_id = IW'(N_SLV);
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((addr & mask[i*DW +: DW]) == base[i*DW +: DW]) dec_id = IW'(i);
  end
endmodule

// File: rtl/udm_bus_split.sv
// One master to N_SLV slaves with in-order outstanding reads bound to a single slot,
// plus an internal error slot answering unmapped accesses.
module udm_bus_split
  import udm_bus_pkg::*;
#(
  parameter int                  N_SLV     = 4,
  parameter int                  MAX_OUTST = 4,
  parameter logic [N_SLV*DW-1:0] SLV_BASE  = (N_SLV*DW)'(def_base()),
  parameter logic [N_SLV*DW-1:0] SLV_MASK  = {N_SLV{32'hF000_0000}},
  parameter logic [DW-1:0]       ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m_req_i,
  input  logic                m_we_i,
  input  logic [DW-1:0]       m_addr_bi,
  input  logic [BW-1:0]       m_be_bi,
  input  logic [DW-1:0]       m_wdata_bi,
  output logic                m_ack_o,
  output logic                m_resp_o,
  output logic [DW-1:0]       m_rdata_bo,
  output logic [N_SLV-1:0]    s_req_o,
  output logic                s_we_o,
  output logic [DW-1:0]       s_addr_bo,
  output logic [BW-1:0]       s_be_bo,
  output logic [DW-1:0]       s_wdata_bo,
  input  logic [N_SLV-1:0]    s_ack_i,
  input  logic [N_SLV-1:0]    s_resp_i,
  input  logic [N_SLV*DW-1:0] s_rdata_bi,
  output logic                decerr_o
);
  localparam int IW = slot_w(N_SLV);
  localparam int CW = slot_w(MAX_OUTST);

  logic [IW-1:0] dec_id, cur_id;
  logic [CW-1:0] cnt, cnt_eff;
  logic          err_resp, dec_err, cur_err, stall, acc_rd;
  logic          sel_ack, sel_resp;
  logic [DW-1:0] sel_rdata;

  udm_bus_decoder #(.N_SLV(N_SLV), .IW(IW)) u_dec (
    .addr   (m_addr_bi),
    .base   (SLV_BASE),
    .mask   (SLV_MASK),
    .dec_id (dec_id)
  );

  assign s_we_o     = m_we_i;
  assign s_addr_bo  = m_addr_bi;
  assign s_be_bo    = m_be_bi;
  assign s_wdata_bo = m_wdata_bi;

  always_comb begin
    sel_ack   = 1'b0;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (dec_id == IW'(i)) sel_ack = s_ack_i[i];
      if (cur_id == IW'(i)) begin
        sel_resp  = s_resp_i[i];
        sel_rdata = s_rdata_bi[i*DW +: DW];
      end
    end
  end

  assign dec_err    = (dec_id == IW'(N_SLV));
  assign cur_err    = (cur_id == IW'(N_SLV));
  assign m_resp_o   = (cnt != '0) & (cur_err ? err_resp : sel_resp);
  assign m_rdata_bo = m_resp_o ? (cur_err ? ERR_RDATA : sel_rdata) : '0;

  // The response retiring this cycle frees its slot, so a new request to another
  // slave (or past the full limit) can be accepted in the same cycle.
  assign cnt_eff = cnt - CW'(m_resp_o);
  assign stall   = rst_i | ((cnt_eff != '0) & (dec_id != cur_id))
                 | (!m_we_i & (cnt_eff == CW'(MAX_OUTST)));

  always_comb begin
    s_req_o = '0;
    for (int i = 0; i < N_SLV; i++)
      s_req_o[i] = m_req_i & !stall & (dec_id == IW'(i));
  end

  assign m_ack_o = m_req_i & !stall & (dec_err | sel_ack);
  assign acc_rd  = m_req_i & m_ack_o & !m_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      cur_id   <= '0;
      err_resp <= 1'b0;
      decerr_o <= 1'b0;
    end else begin
      cnt      <= cnt + CW'(acc_rd) - CW'(m_resp_o);
      if (acc_rd) cur_id <= dec_id;
      err_resp <= acc_rd & dec_err;
      decerr_o <= m_req_i & m_ack_o & dec_err;
    end
  end
endmodule

// File: tb/tb_udm_bus_split.sv
// Randomized bench for udm_bus_split against a queue-based model of outstanding reads.
module tb_udm_bus_split;
  localparam int N   = 4;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_i, m_req_i, m_we_i;
  logic [31:0]   m_addr_bi, m_wdata_bi;
  logic [3:0]    m_be_bi;
  logic          m_ack_o, m_resp_o, s_we_o, decerr_o;
  logic [31:0]   m_rdata_bo, s_addr_bo, s_wdata_bo;
  logic [N-1:0]  s_req_o, s_ack_i, s_resp_i;
  logic [3:0]    s_be_bo;
  logic [N*32-1:0] s_rdata_bi;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  udm_bus_split dut (
    .clk_i(clk), .rst_i(rst_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_addr_bi(m_addr_bi), .m_be_bi(m_be_bi), .m_wdata_bi(m_wdata_bi),
    .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
    .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i),
    .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .decerr_o(decerr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Default map: top nibble selects the slave, anything at or above N is unmapped.
  function automatic int decode(input logic [31:0] a);
    return (int'(a[31:28]) < N) ? int'(a[31:28]) : N;
  endfunction

  // Model state: slot id of every outstanding read, oldest first.
  int pend[$];
  bit err_due = 0, dec_exp = 0;

  always @(negedge clk) begin
    int own, d, left;
    bit resp_e, st, acc;
    logic [31:0] rdata_e;
    logic [N-1:0] sreq_e;
    #2;
    resp_e = 0; rdata_e = '0; own = 0;
    if (pend.size() > 0) begin
      own = pend[$];
      resp_e = (own == N) ? err_due : s_resp_i[own];
      if (resp_e) rdata_e = (own == N) ? 32'hDEAD_BEEF : s_rdata_bi[own*32 +: 32];
    end
    left = pend.size() - int'(resp_e);
    d = decode(m_addr_bi);
    st = rst_i || (left != 0 && d != own) || (!m_we_i && left == MAX);
    acc = m_req_i && !st && (d == N || s_ack_i[d]);
    sreq_e = '0;
    if (m_req_i && !st && d < N) sreq_e[d] = 1'b1;
    if (chk_en) begin
      chk("m_ack", 32'(m_ack_o), 32'(acc));
      chk("s_req", 32'(s_req_o), 32'(sreq_e));
      chk("m_resp", 32'(m_resp_o), 32'(resp_e));
      chk("m_rdata", m_rdata_bo, rdata_e);
      chk("decerr", 32'(decerr_o), 32'(dec_exp));
      chk("bcast", {s_addr_bo[31:5], s_we_o, s_be_bo}, {m_addr_bi[31:5], m_we_i, m_be_bi});
      chk("wdata", s_wdata_bo, m_wdata_bi);
    end
    if (rst_i) begin
      pend.delete();
      err_due = 0;
      dec_exp = 0;
    end else begin
      if (resp_e) void'(pend.pop_front());
      if (acc && !m_we_i) pend.push_back(d);
      err_due = acc && !m_we_i && d == N;
      dec_exp = acc && d == N;
    end
  end

  task automatic drive(input bit req, input bit we, input logic [31:0] addr,
                       input logic [N-1:0] ack, input logic [N-1:0] resp);
    @(negedge clk);
    rst_i = 0; m_req_i = req; m_we_i = we; m_addr_bi = addr;
    s_ack_i = ack; s_resp_i = resp;
  endtask

  initial begin
    rst_i = 1; m_req_i = 1; m_we_i = 0; m_addr_bi = 32'h1000_0000;
    m_be_bi = 4'hF; m_wdata_bi = 32'h0; s_ack_i = '1; s_resp_i = '1;
    s_rdata_bi = {32'h0000_0033, 32'h0000_0022, 32'h1234_5678, 32'h0000_0011};
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    #2;
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    chk("rst_sreq", 32'(s_req_o), 32'd0);
    chk("rst_resp", 32'(m_resp_o), 32'd0);

    // Slot 1 read, response three cycles later
    drive(1, 0, 32'h1000_0004, 4'b0010, 4'b0000); #2;
    chk("d31_sreq", 32'(s_req_o), 32'h2);
    chk("d31_ack", 32'(m_ack_o), 32'd1);
    drive(0, 0, 32'h0, 4'b0000, 4'b0000);
    drive(0, 0, 32'h0, 4'b0000, 4'b0000); #2;
    chk("d31_wait", 32'(m_resp_o), 32'd0);
    drive(0, 0, 32'h0, 4'b0000, 4'b0010); #2;
    chk("d31_resp", 32'(m_resp_o), 32'd1);
    chk("d31_rdata", m_rdata_bo, 32'h1234_5678);
    drive(0, 0, 32'h0, 4'b0000, 4'b0010); #2;
    chk("d31_drained", 32'(m_resp_o), 32'd0);

    // Unmapped read answered by the error slot
    drive(1, 0, 32'h5000_0000, 4'b0000, 4'b0000); #2;
    chk("d34_ack", 32'(m_ack_o), 32'd1);
    chk("d34_sreq", 32'(s_req_o), 32'd0);
    drive(0, 0, 32'h0, 4'b0000, 4'b0000); #2;
    chk("d34_resp", 32'(m_resp_o), 32'd1);
    chk("d34_rdata", m_rdata_bo, 32'hDEAD_BEEF);
    chk("d34_decerr", 32'(decerr_o), 32'd1);

    // Spurious response while idle
    drive(0, 0, 32'h0, 4'b0000, 4'b1000); #2;
    chk("d36_resp", 32'(m_resp_o), 32'd0);
    chk("d36_rdata", m_rdata_bo, 32'd0);
    chk("d36_decerr", 32'(decerr_o), 32'd0);

    // Slot switch waits for the slot-0 response, then goes through that cycle
    drive(1, 0, 32'h0000_0010, 4'b0001, 4'b0000);
    drive(1, 0, 32'h2000_0000, 4'b0100, 4'b0000); #2;
    chk("d33_stall", 32'(m_ack_o), 32'd0);
    chk("d33_sreq0", 32'(s_req_o), 32'd0);
    drive(1, 0, 32'h2000_0000, 4'b0100, 4'b0001); #2;
    chk("d33_ack", 32'(m_ack_o), 32'd1);
    chk("d33_sreq", 32'(s_req_o), 32'h4);
    chk("d33_rdata0", m_rdata_bo, 32'h0000_0011);
    drive(0, 0, 32'h0, 4'b0000, 4'b0100); #2;
    chk("d33_resp2", m_rdata_bo, 32'h0000_0022);

    // Random traffic with varying slave response rates and occasional reset
    for (int c = 0; c < 4000; c++) begin
      int sl, rp;
      @(negedge clk);
      rp = (c / 250) % 3 == 0 ? 4 : ((c / 250) % 3 == 1 ? 30 : 75);
      rst_i   = ($urandom_range(0, 99) < 2);
      m_req_i = ($urandom_range(0, 99) < 75);
      m_we_i  = ($urandom_range(0, 99) < 25);
      sl = $urandom_range(0, 11);
      m_addr_bi = $urandom;
      m_addr_bi[31:28] = (sl < 9) ? 4'(sl % 4) : (sl == 9 ? 4'h5 : 4'hF);
      m_be_bi = 4'($urandom);
      m_wdata_bi = $urandom;
      for (int k = 0; k < N; k++) begin
        s_ack_i[k]  = ($urandom_range(0, 99) < 60);
        s_resp_i[k] = ($urandom_range(0, 99) < rp);
        s_rdata_bi[k*32 +: 32] = $urandom;
      end
    end
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
